id_ex_pipe_reg: RTL
===================

// Module: id_ex_pipe_reg
// PURPOSE
//  ID/EX pipeline register for the 5-stage MIPS core. Captures decode-stage control (RegWrite..Jump)
//  plus operands/fields each cycle and presents them to EX. Handles external stall and flush, and
//  inserts a one-cycle bubble on load-use hazards. Keeps a saturating bubble counter for perf debug.
// PARAMETERS
//  DW       32  datapath width (pc_plus4, operands, immediate)
//  CNT_W    16  width of bubble_count
// PORTS
//  clk            in   1     rising-edge clock (single clock domain)
//  reset_n        in   1     synchronous, active-low reset
//  id_reg_write   in   1     decode RegWrite
//  id_mem_to_reg  in   1     decode MemToReg
//  id_mem_read    in   1     decode MemRead
//  id_mem_write   in   1     decode MemWrite
//  id_branch      in   1     decode Branch
//  id_reg_dst     in   1     decode RegDst (1 = dest is rt, 0 = dest is rd)
//  id_alu_op      in   4     decode ALUOp
//  id_alu_src     in   1     decode ALUSrc
//  id_jump        in   2     decode Jump (00 none, 01 JR, 10 JR forwarded)
//  id_pc_plus4    in   DW    PC+4 of decoded instruction
//  id_rdata1/2    in   DW    register file read data (rs/rt)
//  id_imm         in   DW    sign-extended immediate
//  id_rs/rt/rd    in   5     register fields
//  id_shamt       in   5     shift amount
//  stall_in       in   1     hold current ID/EX contents (e.g. memory wait)
//  flush_in       in   1     squash: load bubble (taken branch/jump)
//  ex_*           out  —     registered copies of every id_* input, same widths
//  ex_valid       out  1     1 = ex_* holds a real instruction, 0 = bubble
//  ex_dest        out  5     ex_reg_dst ? ex_rt : ex_rd (combinational from regs)
//  load_use_stall out  1     combinational; freeze PC and IF/ID this cycle
//  bubble_count   out  CNT_W bubbles inserted since reset, saturating
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge): all ex_* = 0, ex_valid=0, bubble_count=0. Reset wins over all.
//  - Latency: 1 cycle, id_* sampled at posedge appear on ex_* after it.
//  - load_use_stall = ex_valid & ex_mem_read & (ex_dest!=0) & (ex_dest==id_rs | ex_dest==id_rt).
//  - Per-posedge priority: flush_in > load_use_stall > stall_in > normal load.
//    flush_in:       bubble (all ex_ control = 0, ex_valid=0; data fields don't-care, cleared to 0).
//    load_use_stall: bubble as above; upstream holds ID, so next cycle same instr reloads; stall
//                    therefore lasts exactly 1 cycle per hazard.
//    stall_in:       all ex_* and ex_valid hold value.
//    normal:         ex_* <= id_*, ex_valid <= 1.
//  - Bubble guarantees ex_reg_write=ex_mem_write=ex_mem_read=ex_branch=0, ex_jump=00: no arch effect.
//  - bubble_count increments on every bubble insertion (flush or load-use), saturates at all-ones.
//    Simultaneous flush+load-use counts once. Held (stall_in) cycles do not count.
//  - load_use_stall never asserted while ex_valid=0, so back-to-back bubbles cannot deadlock.
//  - Reset mid-stall: stall state lost, EX empty; no hazard possible next cycle.
// CONFIGURATION
//  LOAD_USE_STALL_EN defined: hazard detection as above.
//  Not defined: load_use_stall tied 0, no load-use bubbles; software must pad NOPs after lw.
//  flush/stall/counter behaviour identical in both builds.
// TESTING
//  1 reset_n=0 with nonzero id_* -> after posedge all ex_*=0, ex_valid=0, bubble_count=0.
//  2 id add (RegWrite=1, ALUOp=0001, rd=3) -> next cycle ex_reg_write=1, ex_alu_op=0001, ex_dest=3, ex_valid=1.
//  3 lw $5 in EX, id rs=5 -> load_use_stall=1, next cycle ex_valid=0, bubble_count=1; then instr loads.
//  4 lw $0 in EX, id rs=0 -> load_use_stall=0 (r0 exempt); without LOAD_USE_STALL_EN case 3 gives 0.
//  5 flush_in=1 with stall_in=1 and load-use -> bubble, bubble_count +1 only; stall_in alone holds ex_*.
//  6 force 2^CNT_W+3 flushes -> bubble_count stays 16'hFFFF.

Source files
------------

// File: rtl/id_ex_pipe_reg_if.sv
// ID/EX boundary bundle: decode-side fields, stall/flush controls, and the registered EX-side copies.
// master = the surrounding pipeline that drives id_* and control; slave = the pipeline register itself.
interface id_ex_pipe_reg_if #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
);
    logic             id_reg_write;
    logic             id_mem_to_reg;
    logic             id_mem_read;
    logic             id_mem_write;
    logic             id_branch;
    logic             id_reg_dst;
    logic [3:0]       id_alu_op;
    logic             id_alu_src;
    logic [1:0]       id_jump;
    logic [DW-1:0]    id_pc_plus4;
    logic [DW-1:0]    id_rdata1;
    logic [DW-1:0]    id_rdata2;
    logic [DW-1:0]    id_imm;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic [4:0]       id_rd;
    logic [4:0]       id_shamt;
    logic             stall_in;
    logic             flush_in;

    logic             ex_reg_write;
    logic             ex_mem_to_reg;
    logic             ex_mem_read;
    logic             ex_mem_write;
    logic             ex_branch;
    logic             ex_reg_dst;
    logic [3:0]       ex_alu_op;
    logic             ex_alu_src;
    logic [1:0]       ex_jump;
    logic [DW-1:0]    ex_pc_plus4;
    logic [DW-1:0]    ex_rdata1;
    logic [DW-1:0]    ex_rdata2;
    logic [DW-1:0]    ex_imm;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic [4:0]       ex_rd;
    logic [4:0]       ex_shamt;
    logic             ex_valid;
    logic [4:0]       ex_dest;
    logic             load_use_stall;
    logic [CNT_W-1:0] bubble_count;

    modport master (
        output id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_reg_dst,
               id_alu_op, id_alu_src, id_jump, id_pc_plus4, id_rdata1, id_rdata2, id_imm,
               id_rs, id_rt, id_rd, id_shamt, stall_in, flush_in,
        input  ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_reg_dst,
               ex_alu_op, ex_alu_src, ex_jump, ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_shamt, ex_valid, ex_dest, load_use_stall, bubble_count
    );

    modport slave (
        input  id_reg_write, id_mem_to_reg, id_mem_read, id_mem_write, id_branch, id_reg_dst,
               id_alu_op, id_alu_src, id_jump, id_pc_plus4, id_rdata1, id_rdata2, id_imm,
               id_rs, id_rt, id_rd, id_shamt, stall_in, flush_in,
        output ex_reg_write, ex_mem_to_reg, ex_mem_read, ex_mem_write, ex_branch, ex_reg_dst,
               ex_alu_op, ex_alu_src, ex_jump, ex_pc_plus4, ex_rdata1, ex_rdata2, ex_imm,
               ex_rs, ex_rt, ex_rd, ex_shamt, ex_valid, ex_dest, load_use_stall, bubble_count
    );
endinterface

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with flush, external stall, load-use bubble insertion and a saturating bubble counter.
// Define LOAD_USE_STALL_EN to enable load-use hazard detection; otherwise load_use_stall is tied low.
module id_ex_pipe_reg #(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input logic              clk,
    input logic              reset_n,
    id_ex_pipe_reg_if.slave  bus
);
    typedef struct packed {
        logic          reg_write;
        logic          mem_to_reg;
        logic          mem_read;
        logic          mem_write;
        logic          branch;
        logic          reg_dst;
        logic [3:0]    alu_op;
        logic          alu_src;
        logic [1:0]    jump;
        logic [DW-1:0] pc_plus4;
        logic [DW-1:0] rdata1;
        logic [DW-1:0] rdata2;
        logic [DW-1:0] imm;
        logic [4:0]    rs;
        logic [4:0]    rt;
        logic [4:0]    rd;
        logic [4:0]    shamt;
    } stage_t;

    stage_t           id_s;
    stage_t           ex_q;
    logic             valid_q;
    logic [CNT_W-1:0] bubble_q;
    logic [4:0]       dest;
    logic             hazard;
    logic             bubble;

    always_comb begin
        id_s.reg_write  = bus.id_reg_write;
        id_s.mem_to_reg = bus.id_mem_to_reg;
        id_s.mem_read   = bus.id_mem_read;
        id_s.mem_write  = bus.id_mem_write;
        id_s.branch     = bus.id_branch;
        id_s.reg_dst    = bus.id_reg_dst;
        id_s.alu_op     = bus.id_alu_op;
        id_s.alu_src    = bus.id_alu_src;
        id_s.jump       = bus.id_jump;
        id_s.pc_plus4   = bus.id_pc_plus4;
        id_s.rdata1     = bus.id_rdata1;
        id_s.rdata2     = bus.id_rdata2;
        id_s.imm        = bus.id_imm;
        id_s.rs         = bus.id_rs;
        id_s.rt         = bus.id_rt;
        id_s.rd         = bus.id_rd;
        id_s.shamt      = bus.id_shamt;
    end

    assign dest = ex_q.reg_dst ? ex_q.rt : ex_q.rd;

    // r0 is never a real producer, and an empty EX slot can never cause a hazard.
`ifdef LOAD_USE_STALL_EN
    assign hazard = valid_q & ex_q.mem_read & (dest != 5'd0) &
                    ((dest == bus.id_rs) | (dest == bus.id_rt));
`else
    assign hazard = 1'b0;
`endif

    assign bubble = bus.flush_in | hazard;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else if (bubble) begin
            ex_q    <= '0;
            valid_q <= 1'b0;
        end else if (!bus.stall_in) begin
            ex_q    <= id_s;
            valid_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            bubble_q <= '0;
        end else if (bubble && (bubble_q != {CNT_W{1'b1}})) begin
            bubble_q <= bubble_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign bus.ex_reg_write   = ex_q.reg_write;
    assign bus.ex_mem_to_reg  = ex_q.mem_to_reg;
    assign bus.ex_mem_read    = ex_q.mem_read;
    assign bus.ex_mem_write   = ex_q.mem_write;
    assign bus.ex_branch      = ex_q.branch;
    assign bus.ex_reg_dst     = ex_q.reg_dst;
    assign bus.ex_alu_op      = ex_q.alu_op;
    assign bus.ex_alu_src     = ex_q.alu_src;
    assign bus.ex_jump        = ex_q.jump;
    assign bus.ex_pc_plus4    = ex_q.pc_plus4;
    assign bus.ex_rdata1      = ex_q.rdata1;
    assign bus.ex_rdata2      = ex_q.rdata2;
    assign bus.ex_imm         = ex_q.imm;
    assign bus.ex_rs          = ex_q.rs;
    assign bus.ex_rt          = ex_q.rt;
    assign bus.ex_rd          = ex_q.rd;
    assign bus.ex_shamt       = ex_q.shamt;
    assign bus.ex_valid       = valid_q;
    assign bus.ex_dest        = dest;
    assign bus.load_use_stall = hazard;
    assign bus.bubble_count   = bubble_q;
endmodule
